// File: rtl/ccc_lock_reset_sequencer.sv
// ---------------------------------------------------------------------------
// ccc_lock_reset_sequencer
//
// Turns the PLL lock flag from the clock conditioning block into a clean,
// debounced fabric reset for logic running on the same clock. Reset is
// released only after lock has been stable for a window plus a hold time,
// and is re-asserted on loss of lock or on a soft request. Each loss of
// lock while running is counted in a saturating counter.
//
// Ports
//   clk           in   fabric clock; the only clock
//   reset         in   synchronous, active-high block reset
//   lock          in   PLL lock, asynchronous to clk (synchronised here)
//   soft_rst_req  in   one-cycle pulse: re-run the reset hold period
//   fab_reset_n   out  active-low reset to downstream logic (1 only in RUN)
//   ready         out  1 while in RUN
//   lock_lost     out  one-cycle pulse on each RUN -> WAIT_LOCK transition
//   loss_cnt      out  saturating count of lock_lost pulses
//   state         out  0=WAIT_LOCK 1=STABILIZE 2=HOLD 3=RUN (debug)
// ---------------------------------------------------------------------------
module ccc_lock_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_CNT_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lock,
    input  logic                      soft_rst_req,
    output logic                      fab_reset_n,
    output logic                      ready,
    output logic                      lock_lost,
    output logic [LOSS_CNT_WIDTH-1:0] loss_cnt,
    output logic [1:0]                state
);

    // One shared counter serves both the stability window and the hold time,
    // so it is sized for the longer of the two.
    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0]    sync_reg;
    logic                      lock_s;
    state_t                    state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      fab_reset_n_reg;
    logic                      ready_reg;
    logic                      lock_lost_reg;
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt_reg;

    // Lock synchroniser: the only place the asynchronous lock is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync_reg[SYNC_STAGES-1];

    // Sequencer FSM. Outputs are updated alongside the state so that
    // fab_reset_n and ready are registered and track state==RUN exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= WAIT_LOCK;
            cnt_reg         <= '0;
            fab_reset_n_reg <= 1'b0;
            ready_reg       <= 1'b0;
            lock_lost_reg   <= 1'b0;
            loss_cnt_reg    <= '0;
        end else begin
            lock_lost_reg <= 1'b0;
            case (state_reg)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_reg <= STABILIZE;
                        cnt_reg   <= '0;
                    end
                end

                // A lock glitch here just restarts the window; it is not a
                // loss of lock because the fabric was never released.
                STABILIZE: begin
                    if (!lock_s) begin
                        state_reg <= WAIT_LOCK;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // A soft request while holding restarts the hold period.
                HOLD: begin
                    if (!lock_s) begin
                        state_reg <= WAIT_LOCK;
                        cnt_reg   <= '0;
                    end else if (soft_rst_req) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == HOLD_LAST) begin
                        state_reg       <= RUN;
                        cnt_reg         <= '0;
                        fab_reset_n_reg <= 1'b1;
                        ready_reg       <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // Lock loss takes priority over a coincident soft request.
                RUN: begin
                    if (!lock_s) begin
                        state_reg       <= WAIT_LOCK;
                        cnt_reg         <= '0;
                        fab_reset_n_reg <= 1'b0;
                        ready_reg       <= 1'b0;
                        lock_lost_reg   <= 1'b1;
                        if (loss_cnt_reg != {LOSS_CNT_WIDTH{1'b1}}) begin
                            loss_cnt_reg <= loss_cnt_reg + 1'b1;
                        end
                    end else if (soft_rst_req) begin
                        state_reg       <= HOLD;
                        cnt_reg         <= '0;
                        fab_reset_n_reg <= 1'b0;
                        ready_reg       <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= WAIT_LOCK;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign fab_reset_n = fab_reset_n_reg;
    assign ready       = ready_reg;
    assign lock_lost   = lock_lost_reg;
    assign loss_cnt    = loss_cnt_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ccc_lock_reset_sequencer
//
// Directed bench for the lock/reset sequencer with SYNC_STAGES=2,
// LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, LOSS_CNT_WIDTH=3.
// Outputs are packed into obs = {state, fab_reset_n, ready, lock_lost,
// loss_cnt} and compared 1 ns after the rising edge against hand-computed
// values. Edge numbers in comments count from the first edge that samples
// the new lock level.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccc_lock_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       lock;
    logic       soft_rst_req;
    logic       fab_reset_n;
    logic       ready;
    logic       lock_lost;
    logic [2:0] loss_cnt;
    logic [1:0] state;

    logic [7:0] obs;
    logic [7:0] exp_v;
    int         checks;
    int         passed;
    int         pulse_cnt;
    int         pulse_base;

    assign obs = {state, fab_reset_n, ready, lock_lost, loss_cnt};

    ccc_lock_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .LOSS_CNT_WIDTH     (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lock         (lock),
        .soft_rst_req (soft_rst_req),
        .fab_reset_n  (fab_reset_n),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .loss_cnt     (loss_cnt),
        .state        (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (lock_lost === 1'b1) pulse_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a given state; an expired bound counts as a failure.
    task automatic wait_state(input logic [1:0] s, input int limit, input string name);
        int k;
        k = 0;
        while (state !== s && k < limit) begin
            tick();
            k++;
        end
        checks++;
        if (state !== s) $display("FAIL %s timeout: state got %0d want %0d", name, state, s);
        else passed++;
    endtask

    task automatic restart();
        reset = 1'b1;
        lock  = 1'b0;
        soft_rst_req = 1'b0;
        tick();
        reset = 1'b0;
        lock  = 1'b1;
        wait_state(2'd3, 40, "restart_run");
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lock  = 1'b1;
        soft_rst_req = 1'b0;
        repeat (3) tick();
        exp_v = {2'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL reset_state got %b want %b", obs, exp_v);
        else passed++;
        lock = 1'b0;
        tick();
    endtask

    task automatic test_startup();
        reset = 1'b0;
        lock  = 1'b1;
        tick(); tick();                               // edge 2
        exp_v = {2'd0, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL startup_e2 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 3
        exp_v = {2'd1, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL startup_e3 got %b want %b", obs, exp_v);
        else passed++;
        repeat (7) tick();                            // edge 10
        checks++;
        if (obs !== exp_v) $display("FAIL startup_e10 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 11
        exp_v = {2'd2, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL startup_e11 got %b want %b", obs, exp_v);
        else passed++;
        repeat (3) tick();                            // edge 14
        checks++;
        if (obs !== exp_v) $display("FAIL startup_e14 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 15
        exp_v = {2'd3, 3'b110, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL startup_e15 got %b want %b", obs, exp_v);
        else passed++;
    endtask

    task automatic test_glitch();
        reset = 1'b1;
        lock  = 1'b0;
        tick();
        reset = 1'b0;
        lock  = 1'b1;
        pulse_base = pulse_cnt;
        repeat (4) tick();                            // edge 4, STABILIZE
        lock = 1'b0;
        tick();                                       // edge 5 samples 0
        lock = 1'b1;
        tick();                                       // edge 6
        exp_v = {2'd1, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL glitch_e6 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 7
        exp_v = {2'd0, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL glitch_e7 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 8, window restarts
        exp_v = {2'd1, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL glitch_e8 got %b want %b", obs, exp_v);
        else passed++;
        repeat (7) tick();                            // edge 15
        checks++;
        if (obs !== exp_v) $display("FAIL glitch_e15 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 16
        exp_v = {2'd2, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL glitch_e16 got %b want %b", obs, exp_v);
        else passed++;
        repeat (4) tick();                            // edge 20
        exp_v = {2'd3, 3'b110, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL glitch_e20 got %b want %b", obs, exp_v);
        else passed++;
        checks++;
        if (pulse_cnt - pulse_base !== 0)
            $display("FAIL glitch_pulses got %0d want 0", pulse_cnt - pulse_base);
        else passed++;
    endtask

    task automatic test_lock_loss();
        lock = 1'b0;
        tick(); tick();                               // edge 2 after drop
        exp_v = {2'd3, 3'b110, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL loss_e2 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 3
        exp_v = {2'd0, 3'b001, 3'd1};
        checks++;
        if (obs !== exp_v) $display("FAIL loss_e3 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 4: pulse ends
        exp_v = {2'd0, 3'b000, 3'd1};
        checks++;
        if (obs !== exp_v) $display("FAIL loss_e4 got %b want %b", obs, exp_v);
        else passed++;
        lock = 1'b1;
        repeat (3) tick();                            // relock edge 3
        exp_v = {2'd1, 3'b000, 3'd1};
        checks++;
        if (obs !== exp_v) $display("FAIL relock_e3 got %b want %b", obs, exp_v);
        else passed++;
        repeat (11) tick();                           // edge 14
        exp_v = {2'd2, 3'b000, 3'd1};
        checks++;
        if (obs !== exp_v) $display("FAIL relock_e14 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 15
        exp_v = {2'd3, 3'b110, 3'd1};
        checks++;
        if (obs !== exp_v) $display("FAIL relock_e15 got %b want %b", obs, exp_v);
        else passed++;
    endtask

    task automatic test_saturation();
        logic [2:0] want_cnt;
        restart();
        pulse_base = pulse_cnt;
        for (int n = 1; n <= 9; n++) begin
            want_cnt = (n > 7) ? 3'd7 : 3'(n);
            lock = 1'b0;
            repeat (3) tick();
            exp_v = {2'd0, 3'b001, want_cnt};
            checks++;
            if (obs !== exp_v) $display("FAIL sat_loss%0d got %b want %b", n, obs, exp_v);
            else passed++;
            lock = 1'b1;
            wait_state(2'd3, 40, "sat_relock");
        end
        checks++;
        if (pulse_cnt - pulse_base !== 9)
            $display("FAIL sat_pulses got %0d want 9", pulse_cnt - pulse_base);
        else passed++;
    endtask

    task automatic test_soft_reset();
        restart();
        // Plain soft request: four cycles in HOLD, then RUN.
        soft_rst_req = 1'b1;
        tick();                                       // edge e
        soft_rst_req = 1'b0;
        exp_v = {2'd2, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL soft_e0 got %b want %b", obs, exp_v);
        else passed++;
        repeat (3) tick();                            // e+3
        checks++;
        if (obs !== exp_v) $display("FAIL soft_e3 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // e+4
        exp_v = {2'd3, 3'b110, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL soft_e4 got %b want %b", obs, exp_v);
        else passed++;
        // Second request during HOLD restarts the hold count.
        soft_rst_req = 1'b1;
        tick();                                       // edge e
        soft_rst_req = 1'b0;
        tick();                                       // e+1
        soft_rst_req = 1'b1;
        tick();                                       // e+2: hold restarts
        soft_rst_req = 1'b0;
        repeat (3) tick();                            // e+5
        exp_v = {2'd2, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL soft_hold_e5 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // e+6
        exp_v = {2'd3, 3'b110, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL soft_hold_e6 got %b want %b", obs, exp_v);
        else passed++;
        // Soft request coincident with synced lock loss: loss wins.
        lock = 1'b0;
        tick(); tick();
        soft_rst_req = 1'b1;
        tick();                                       // edge 3 after drop
        soft_rst_req = 1'b0;
        exp_v = {2'd0, 3'b001, 3'd1};
        checks++;
        if (obs !== exp_v) $display("FAIL soft_vs_loss got %b want %b", obs, exp_v);
        else passed++;
        lock = 1'b1;
        wait_state(2'd3, 40, "soft_relock");
    endtask

    task automatic test_reset_mid();
        // Reset while in RUN with a nonzero loss count.
        reset = 1'b1;
        tick();
        exp_v = {2'd0, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL rst_run got %b want %b", obs, exp_v);
        else passed++;
        reset = 1'b0;
        tick(); tick();                               // edge 2
        checks++;
        if (obs !== exp_v) $display("FAIL rst_run_e2 got %b want %b", obs, exp_v);
        else passed++;
        tick();                                       // edge 3
        exp_v = {2'd1, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL rst_run_e3 got %b want %b", obs, exp_v);
        else passed++;
        // Reset while in HOLD.
        wait_state(2'd2, 20, "rst_hold_reach");
        tick();
        reset = 1'b1;
        tick();
        exp_v = {2'd0, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL rst_hold got %b want %b", obs, exp_v);
        else passed++;
        reset = 1'b0;
        repeat (3) tick();
        exp_v = {2'd1, 3'b000, 3'd0};
        checks++;
        if (obs !== exp_v) $display("FAIL rst_hold_e3 got %b want %b", obs, exp_v);
        else passed++;
        wait_state(2'd3, 20, "rst_hold_run");
    endtask

    initial begin
        checks       = 0;
        passed       = 0;
        pulse_cnt    = 0;
        pulse_base   = 0;
        reset        = 1'b1;
        lock         = 1'b0;
        soft_rst_req = 1'b0;
        test_reset();
        test_startup();
        test_glitch();
        test_lock_loss();
        test_saturation();
        test_soft_reset();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
